// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with a two-register bus port (RXD data, STAT flags/irq enable).
// Start-bit detection on the synchronized line, mid-bit sampling with a 16x oversample tick.
module uart_rx_port #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600,
    parameter logic [31:0] BASE   = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RX,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout
);

    localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [31:0]      STAT_ADDR = BASE + 32'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic             rx_s1_q, rx_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rxd_q, rxd_d;
    logic             full_q, full_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             irq_en_q, irq_en_d;

    logic tick;
    logic frame_done;
    logic rd_rxd, rd_stat, wr_stat;
    logic unused_wdata;

    assign tick    = (div_q == DIV_LAST);
    assign rd_rxd  = rd && (addr == BASE);
    assign rd_stat = rd && (addr == STAT_ADDR);
    assign wr_stat = wr && (addr == STAT_ADDR);
    assign unused_wdata = ^{wdata[31:4], wdata[2:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= RX;
            rx_s2_q <= rx_s1_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            rxd_q    <= '0;
            full_q   <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            rxd_q    <= rxd_d;
            full_q   <= full_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            irq_en_q <= irq_en_d;
        end
    end

    // Receive FSM: tick_q counts oversample ticks within the current bit period.
    always_comb begin
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s2_q) begin
                    state_d = START;
                    div_d   = '0;
                    tick_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_q == 4'd7) begin
                        if (rx_s2_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_q == 4'd15) begin
                        shift_d = {rx_s2_q, shift_q[7:1]};
                        tick_d  = '0;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_q == 4'd15) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame completion has priority over read-side clears so a new byte is never lost.
    always_comb begin
        rxd_d    = rxd_q;
        full_d   = full_q;
        ovr_d    = ovr_q;
        ferr_d   = ferr_q;
        irq_en_d = irq_en_q;
        if (rd_rxd) begin
            full_d = 1'b0;
        end
        if (rd_stat) begin
            ovr_d = 1'b0;
        end
        if (wr_stat) begin
            irq_en_d = wdata[3];
        end
        if (frame_done) begin
            rxd_d  = shift_q;
            full_d = 1'b1;
            ferr_d = ~rx_s2_q;
            if (full_q) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_rxd) begin
            rdata = {24'b0, rxd_q};
        end else if (rd_stat) begin
            rdata = {28'b0, irq_en_q, ovr_q, ferr_q, full_q};
        end
    end

    assign irqout = irq_en_q & full_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: directed scenarios plus random frames/bus traffic against a
// byte-level model of the receive flags (16 clocks per bit).
module tb_uart_rx_port;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam logic [31:0] BASE   = 32'h4000_0018;
    localparam logic [31:0] STAT   = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        RX;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irqout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_rxd;
    logic       m_full, m_ovr, m_ferr, m_irqen;

    uart_rx_port #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .RX(RX), .rd(rd), .wr(wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irqout(irqout)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_stat();
        return {28'b0, m_irqen, m_ovr, m_ferr, m_full};
    endfunction

    task automatic m_reset();
        m_rxd = 8'h00; m_full = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_irqen = 1'b0;
    endtask

    task automatic m_frame(input logic [7:0] b, input logic stop_bit);
        if (m_full) m_ovr = 1'b1;
        m_rxd  = b;
        m_full = 1'b1;
        m_ferr = ~stop_bit;
    endtask

    // Start bit begins on the first negedge after the call; line returns high at the end.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = bits[i];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic gap();
        repeat (12) @(negedge clk);
    endtask

    // One bus cycle starting now (between edges); model is updated after the edge.
    task automatic bus_op(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input string tag, input bit chk_irq);
        logic [31:0] exp;
        exp = 32'h0;
        if (r) begin
            if (a == BASE) exp = {24'b0, m_rxd};
            else if (a == STAT) exp = m_stat();
        end
        rd = r; wr = w; addr = a; wdata = wd;
        #1;
        chk(tag, rdata, exp);
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
        if (r && a == BASE) m_full = 1'b0;
        if (r && a == STAT) m_ovr = 1'b0;
        if (w && a == STAT) m_irqen = wd[3];
        if (chk_irq) chk("irq", {31'b0, irqout}, {31'b0, m_irqen & m_full});
    endtask

    task automatic rd_op(input logic [31:0] a, input string tag);
        @(negedge clk);
        bus_op(1'b1, 1'b0, a, 32'h0, tag, 1'b1);
    endtask

    task automatic wr_op(input logic [31:0] a, input logic [31:0] wd, input string tag);
        @(negedge clk);
        bus_op(1'b0, 1'b1, a, wd, tag, 1'b1);
    endtask

    task automatic frame(input logic [7:0] b, input logic stop_bit);
        send_frame(b, stop_bit);
        m_frame(b, stop_bit);
        gap();
    endtask

    function automatic logic [31:0] bad_addr();
        logic [31:0] a;
        if ($urandom_range(0, 1) == 0) a = BASE + 32'($urandom_range(1, 3)) + 32'($urandom_range(0, 1) * 4);
        else a = $urandom;
        if (a == BASE || a == STAT) a = a ^ 32'h0000_0100;
        return a;
    endfunction

    initial begin
        reset = 1'b0; RX = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
        m_reset();
        repeat (3) @(negedge clk);
        bus_op(1'b1, 1'b0, STAT, 32'h0, "reset_stat", 1'b1);
        @(negedge clk);
        bus_op(1'b1, 1'b0, BASE, 32'h0, "reset_rxd", 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Basic receive
        frame(8'hA5, 1'b1);
        rd_op(STAT, "a5_stat");
        @(negedge clk);
        bus_op(1'b0, 1'b0, BASE, 32'h0, "no_rd", 1'b1);
        rd_op(BASE, "a5_rxd");
        rd_op(STAT, "a5_stat_after");

        // Interrupt enable
        wr_op(STAT, 32'h8, "wr_irq_en");
        frame(8'h3C, 1'b1);
        chk("irq_high", {31'b0, irqout}, 32'h1);
        rd_op(BASE, "3c_rxd");
        chk("irq_low", {31'b0, irqout}, 32'h0);
        wr_op(STAT, 32'h7, "wr_irq_dis");

        // Overrun
        frame(8'h11, 1'b1);
        frame(8'h22, 1'b1);
        rd_op(STAT, "ovr_stat1");
        rd_op(STAT, "ovr_stat2");
        rd_op(BASE, "ovr_rxd");
        rd_op(STAT, "ovr_stat3");

        // Framing error, then cleared by a good frame
        frame(8'h55, 1'b0);
        rd_op(STAT, "ferr_stat");
        rd_op(BASE, "ferr_rxd");
        frame(8'h9E, 1'b1);
        rd_op(STAT, "ferr_clr_stat");
        rd_op(BASE, "ferr_clr_rxd");

        // Short glitch rejected
        @(negedge clk); RX = 1'b0;
        repeat (4) @(negedge clk); RX = 1'b1;
        repeat (20) @(negedge clk);
        rd_op(STAT, "glitch_stat");

        // Simultaneous rd+wr on STAT, and non-decoded addresses
        wr_op(STAT, 32'h8, "wr_en2");
        @(negedge clk);
        bus_op(1'b1, 1'b1, STAT, 32'h0, "rdwr_stat", 1'b1);
        rd_op(STAT, "rdwr_after");
        wr_op(BASE + 32'd8, 32'h8, "wr_bad");
        wr_op(BASE, 32'hFF, "wr_rxd_ign");
        rd_op(BASE + 32'd8, "rd_bad");
        rd_op(STAT, "bad_after");

        // Frame completion coincident with RXD read (holding register empty)
        fork
            send_frame(8'h6B, 1'b1);
            begin
                repeat (155) @(negedge clk);
                bus_op(1'b1, 1'b0, BASE, 32'h0, "coin_rxd", 1'b0);
            end
        join
        m_frame(8'h6B, 1'b1);
        gap();
        rd_op(STAT, "coin_rxd_stat");
        rd_op(BASE, "coin_rxd_new");

        // Frame completion coincident with STAT read while a byte is pending
        frame(8'h12, 1'b1);
        fork
            send_frame(8'h34, 1'b1);
            begin
                repeat (155) @(negedge clk);
                bus_op(1'b1, 1'b0, STAT, 32'h0, "coin_stat", 1'b0);
            end
        join
        m_frame(8'h34, 1'b1);
        gap();
        rd_op(STAT, "coin_stat_after");
        rd_op(BASE, "coin_stat_rxd");

        // Random frames and bus traffic
        for (int i = 0; i < 16; i++) begin
            logic [7:0]  b;
            logic        sb;
            int          nact;
            b  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            frame(b, sb);
            nact = $urandom_range(0, 3);
            for (int j = 0; j < nact; j++) begin
                case ($urandom_range(0, 4))
                    0: rd_op(BASE, "rnd_rxd");
                    1: rd_op(STAT, "rnd_stat");
                    2: wr_op(STAT, $urandom, "rnd_wr_stat");
                    3: rd_op(bad_addr(), "rnd_rd_bad");
                    default: wr_op(bad_addr(), $urandom, "rnd_wr_bad");
                endcase
            end
        end
        rd_op(STAT, "rnd_final_stat");
        rd_op(BASE, "rnd_final_rxd");

        // Reset during data bit 3 of a frame with irq pending
        wr_op(STAT, 32'h8, "pre_rst_en");
        frame(8'h77, 1'b1);
        chk("pre_rst_irq", {31'b0, irqout}, 32'h1);
        fork
            send_frame(8'hF2, 1'b1);
            begin
                repeat (73) @(negedge clk);
                reset = 1'b0;
                m_reset();
                #1;
                chk("rst_irq", {31'b0, irqout}, 32'h0);
                bus_op(1'b1, 1'b0, STAT, 32'h0, "rst_stat", 1'b1);
                @(negedge clk);
                bus_op(1'b1, 1'b0, BASE, 32'h0, "rst_rxd", 1'b1);
                repeat (20) @(negedge clk);
                reset = 1'b1;
            end
        join
        gap();
        rd_op(STAT, "post_rst_stat");
        rd_op(BASE, "post_rst_rxd");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_port.md
UART_RX_PORT -- requirements
Module: uart_rx_port

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter BASE, default 32'h4000_0018, bus address of RXD; STAT = BASE+4.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 RX  input  1  asynchronous serial line; idles high; 8N1 framing.
REQ-007 rd  input  1  bus read strobe, single cycle, combinational address decode.
REQ-008 wr  input  1  bus write strobe, single cycle.
REQ-009 addr  input  32  bus byte address.
REQ-010 wdata  input  32  bus write data.
REQ-011 rdata  output  32  bus read data; 0 when not addressed or rd=0.
REQ-012 irqout  output  1  receive interrupt request, level.

Function
REQ-013 RX shall pass a 2-flop synchronizer before any use; line-to-FSM latency 2 cycles.
REQ-014 Oversample tick shall fire once every DIV = CLK_HZ/(BAUD*16) cycles (integer truncation, minimum 1); 50 MHz/9600 gives DIV=325.
REQ-015 Tick divider shall free-run in IDLE and restart from 0 on falling-edge detection.
REQ-016 FSM states IDLE, START, DATA, STOP; reset state IDLE.
REQ-017 IDLE->START on synchronized RX=0; tick count cleared.
REQ-018 START: at 8th tick sample RX; 0 -> DATA (tick count and bit index cleared); 1 -> IDLE (glitch rejected, no flags change).
REQ-019 DATA: every 16th tick sample RX into shift register, LSB first; after bit index 7 -> STOP.
REQ-020 STOP: at 16th tick sample RX; on same cycle load RXD holding register, set rx_full, set frame_err if sample=0 else clear it; -> IDLE.
REQ-021 A completed frame while rx_full=1 shall overwrite RXD and set overrun (sticky).
REQ-022 Read of RXD: rdata={24'b0,RXD}; rx_full cleared next edge.
REQ-023 Read of STAT: rdata={28'b0, irq_en, overrun, frame_err, rx_full}; overrun cleared next edge.
REQ-024 Write to STAT: irq_en <= wdata[3]; wdata[2:0] ignored; writes to RXD ignored.
REQ-025 Frame completion and RXD read on same cycle: rx_full stays 1, new byte kept.
REQ-026 Frame completion and STAT read on same cycle: rdata shows pre-edge flags; overrun set by the completion survives.
REQ-027 irqout = irq_en AND rx_full, registered-free combinational from flags.
REQ-028 Addresses other than BASE and BASE+4 shall not alter state and return rdata=0.
REQ-029 Simultaneous rd and wr to STAT: write takes effect, read returns pre-write value.

Reset
REQ-030 reset=0 shall immediately force FSM=IDLE, divider=0, bit index=0, shift register=0, RXD=0, rx_full=0, overrun=0, frame_err=0, irq_en=0, synchronizer flops=1.
REQ-031 Reset mid-frame shall discard partial byte; after release, receiver waits for a new falling edge with no spurious rx_full.
REQ-032 rdata=0 and irqout=0 during reset.

Verification (bench uses CLK_HZ=1_600_000, BAUD=100_000 -> DIV=1, 16 cycles/bit)
REQ-033 Send 0xA5 8N1 -> rx_full=1 at STOP sample; read RXD -> rdata=32'h0000_00A5; next cycle STAT reads 4'b0000.
REQ-034 Write STAT wdata=8, send 0x3C -> irqout rises with rx_full; read RXD -> irqout falls next cycle.
REQ-035 Send 0x11 then 0x22 without reading -> STAT reads 4'b0101, RXD reads 0x22; second STAT read returns 4'b0001, then RXD read returns 4'b0000 on STAT.
REQ-036 Send 0x55 with stop bit held 0 -> rx_full=1, frame_err=1, RXD=0x55; next good frame clears frame_err.
REQ-037 RX low pulse of 4 cycles -> FSM returns to IDLE, all flags 0; assert reset at DATA bit 3 of a frame -> all outputs 0, no byte delivered.
